// File: rtl/sum_signature_checker_if.sv
// sum_signature_checker_if
//   Groups the run-control, sample-stream and status signals of the
//   sum signature checker.
//   master : drives start/length/seed and the sum stream, observes status
//   slave  : the checker itself
// Signals:
//   start         run start pulse
//   length        samples per run, sampled on start
//   seed          initial MISR value, sampled on start
//   valid_in      sum_in carries an adder result
//   sum_in        adder sum, digit 0 in the LSBs
//   busy, done    run status
//   signature     current MISR value
//   sample_count  samples accepted in this run
//   illegal_count samples holding at least one illegal digit (saturating)
interface sum_signature_checker_if #(
  parameter int BITS_OUT    = 25,
  parameter int SIG_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] length;
  logic [SIG_WIDTH-1:0]   seed;
  logic                   valid_in;
  logic [BITS_OUT-1:0]    sum_in;
  logic                   busy;
  logic                   done;
  logic [SIG_WIDTH-1:0]   signature;
  logic [COUNT_WIDTH-1:0] sample_count;
  logic [COUNT_WIDTH-1:0] illegal_count;

  modport master (
    output start, length, seed, valid_in, sum_in,
    input  busy, done, signature, sample_count, illegal_count
  );

  modport slave (
    input  start, length, seed, valid_in, sum_in,
    output busy, done, signature, sample_count, illegal_count
  );
endinterface

// File: rtl/sum_signature_checker.sv
// sum_signature_checker
//   Compresses a run of redundant-radix adder results into a MISR signature,
//   counts accepted samples and counts samples carrying the illegal
//   most-negative digit code. Software compares the final signature with a
//   golden value computed off-chip.
// Ports:
//   pll_clock  the only clock
//   reset      asynchronous, active-high
//   bus        sum_signature_checker_if.slave (control, sample stream, status)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; waiting for start, samples ignored
// RUN   | accepting samples until sample_count reaches the latched length
// DONE  | run finished, final signature held; start begins a new run
module sum_signature_checker #(
  parameter int                   RADIX       = 16,
  parameter int                   DIGITS      = 4,
  parameter int                   SIG_WIDTH   = 32,
  parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
  parameter int                   COUNT_WIDTH = 16
) (
  input  logic                    pll_clock,
  input  logic                    reset,
  sum_signature_checker_if.slave  bus
);

  localparam int DW       = $clog2(RADIX) + 1;
  localparam int BITS_OUT = DW * (DIGITS + 1);
  localparam int CHUNKS   = (BITS_OUT + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int EXT_W    = CHUNKS * SIG_WIDTH;

  // Digit value -RADIX: sign bit set, all magnitude bits clear.
  localparam logic [DW-1:0] ILLEGAL_CODE = {1'b1, {(DW-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SIG_WIDTH-1:0]   sig_q, sig_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] ill_q, ill_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic                   busy_q, done_q;

  logic [EXT_W-1:0]       sum_ext;
  logic [SIG_WIDTH-1:0]   fold_val;
  logic [SIG_WIDTH-1:0]   misr_next;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic                   has_illegal;

  // Fold the sum into SIG_WIDTH bits: zero-extend to whole chunks, XOR them.
  always_comb begin
    sum_ext                 = '0;
    sum_ext[BITS_OUT-1:0]   = bus.sum_in;
    fold_val                = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      fold_val = fold_val ^ sum_ext[c*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  always_comb begin
    has_illegal = 1'b0;
    for (int d = 0; d < DIGITS + 1; d++) begin
      if (bus.sum_in[d*DW +: DW] == ILLEGAL_CODE) begin
        has_illegal = 1'b1;
      end
    end
  end

  // Galois-style MISR step: shift, conditional polynomial feedback, inject.
  assign misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold_val;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    len_d   = len_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sig_d   = bus.seed;
          cnt_d   = '0;
          ill_d   = '0;
          len_d   = bus.length;
          state_d = (bus.length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // start is deliberately ignored here; only samples move the run on.
        if (bus.valid_in) begin
          sig_d = misr_next;
          cnt_d = cnt_inc;
          if (has_illegal && (ill_q != '1)) begin
            ill_d = ill_q + CNT_ONE;
          end
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      ill_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      len_q   <= len_d;
      // Status flops track the next state so they align with state_q.
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.signature     = sig_q;
  assign bus.sample_count  = cnt_q;
  assign bus.illegal_count = ill_q;

endmodule
